// File: rtl/neuro_pkg.sv
// neuro_pkg: shared defaults for the spike event arbiter family
package neuro_pkg;
  localparam int N_NEURONS_DEF = 8;
  localparam int ID_W_DEF = 3;
  localparam int DROP_W_DEF = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search upward from last_grant+1
module rr_pick import neuro_pkg::*; #(
  parameter int N = N_NEURONS_DEF,
  parameter int W = ID_W_DEF
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant_id,
  output logic         any_req
);
  logic [31:0] idx;
  assign any_req = |req;
  // scan farthest candidate first so the nearest set bit after last_grant wins
  always_comb begin
    grant_id = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (32'(last_grant) + 32'(k)) % 32'(N);
      if (req[idx[W-1:0]]) grant_id = idx[W-1:0];
    end
  end
endmodule

// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter: latches neuron spikes and serialises them as round-robin events
module spike_event_arbiter import neuro_pkg::*; #(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic                 evt_valid,
  output logic [ID_W-1:0]      evt_id,
  input  logic                 evt_ready,
  input  logic                 clr_stats,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_cnt
);
  localparam int SW = DROP_W + ID_W + 2;
  localparam logic [DROP_W-1:0] CNT_MAX = '1;
  logic [N_NEURONS-1:0] pending, grant_mask, new_spk, keep, drop_bits;
  logic [ID_W-1:0] last_grant, grant_id;
  logic any_req, load;
  logic [SW-1:0] drop_n, drop_sum;
  rr_pick #(.N(N_NEURONS), .W(ID_W)) u_pick (
    .req(pending),
    .last_grant(last_grant),
    .grant_id(grant_id),
    .any_req(any_req)
  );
  assign load = (!evt_valid || evt_ready) && any_req;
  assign grant_mask = load ? N_NEURONS'(1) << grant_id : '0;
  assign new_spk = ena ? spike_in : '0;
  assign keep = pending & ~grant_mask;
  assign drop_bits = keep & new_spk;
  // a spike onto a still-pending, ungranted neuron is lost; tally how many
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < N_NEURONS; i++) drop_n = drop_n + SW'(drop_bits[i]);
    drop_sum = SW'(drop_cnt) + drop_n;
  end
  // pending set and output slot: load winner when slot frees, else drain on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      last_grant <= ID_W'(N_NEURONS - 1);
      evt_valid <= 1'b0;
      evt_id <= '0;
    end else begin
      pending <= keep | new_spk;
      if (load) begin
        evt_valid <= 1'b1;
        evt_id <= grant_id;
        last_grant <= grant_id;
      end else if (evt_ready) evt_valid <= 1'b0;
    end
  end
  // sticky overflow and saturating drop count; clear wins over a same-cycle drop
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (|drop_bits) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum > SW'(CNT_MAX) ? CNT_MAX : drop_sum[DROP_W-1:0];
    end
  end
endmodule

// File: doc/spike_event_arbiter.md
SPIKE_EVENT_ARBITER -- requirements
Module: spike_event_arbiter

Interface
REQ-001 SHALL have parameter N_NEURONS, default 8, number of neuron spike sources.
REQ-002 SHALL have parameter ID_W, default 3, event ID width, equal to clog2(N_NEURONS).
REQ-003 SHALL have parameter DROP_W, default 8, dropped-spike counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ena  input  1  high = accept new spikes; low = ignore spike_in, keep draining.
REQ-007 SHALL have port spike_in  input  N_NEURONS  one bit per neuron, sampled every cycle, high = spike.
REQ-008 SHALL have port evt_valid  output  1  registered, high = evt_id holds an event.
REQ-009 SHALL have port evt_id  output  ID_W  registered index of the spiking neuron.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts the event in cycles where evt_valid && evt_ready.
REQ-011 SHALL have port clr_stats  input  1  clears overflow and drop_cnt.
REQ-012 SHALL have port overflow  output  1  sticky flag, set when any spike is dropped.
REQ-013 SHALL have port drop_cnt  output  DROP_W  dropped-spike count, saturating.

Function
REQ-014 SHALL keep one pending bit per neuron; when ena=1, spike_in[i]=1 at edge k sets pending[i] after edge k.
REQ-015 SHALL free the output slot in a cycle when evt_valid=0 or (evt_valid && evt_ready).
REQ-016 SHALL, in a cycle with a free output slot and any pending bit set, load the round-robin winner into evt_id, set evt_valid, and clear that pending bit at the same edge.
REQ-017 SHALL choose the round-robin winner as the first set pending bit searching upward from last_grant+1 modulo N_NEURONS; last_grant SHALL update on every load.
REQ-018 SHALL clear evt_valid at the edge where evt_valid && evt_ready and no bit is pending.
REQ-019 SHALL hold evt_valid and evt_id stable while evt_valid && !evt_ready.
REQ-020 SHALL, with pending empty and evt_valid=0, give 2-cycle latency from spike to evt_valid: spike sampled at edge k, evt_valid high after edge k+1.
REQ-021 SHALL sustain one event per cycle while evt_ready=1.
REQ-022 SHALL keep pending[i] set when spike_in[i]=1 arrives in the same cycle pending[i] is granted and cleared; this counts as a new spike, not a drop.
REQ-023 SHALL count a drop when spike_in[i]=1, ena=1, pending[i]=1 and i is not granted that cycle: overflow set, drop_cnt += number of such bits, saturating at 2^DROP_W-1.
REQ-024 SHALL give clr_stats priority over a same-cycle drop: both overflow and drop_cnt are 0 after the edge.
REQ-025 SHALL, when ena=0, ignore spike_in (no set, no drop) while still draining pending bits.

Reset
REQ-026 SHALL, when rst=1 at an edge, clear pending, evt_valid=0, evt_id=0, overflow=0 and drop_cnt=0, and set last_grant=N_NEURONS-1 so neuron 0 wins first.
REQ-027 SHALL, on reset asserted mid-transfer, discard any held event and all pending spikes without issuing a handshake.
REQ-028 SHALL ignore spike_in during cycles where rst=1.

Structure
REQ-029 SHALL place N_NEURONS, ID_W and DROP_W defaults in shared package neuro_pkg.
REQ-030 SHALL implement winner selection in combinational sub-module rr_pick, with inputs req vector and last_grant, and outputs grant_id and any_req.
REQ-031 SHALL use flip-flops for every output, with no combinational path from spike_in to any output.

Verification
REQ-032 SHALL test single spike: after reset, spike_in=8'h04 for 1 cycle with evt_ready=1 -> evt_valid high exactly 1 cycle, evt_id=2, two cycles after the spike.
REQ-033 SHALL test fairness: spike_in=8'hFF for 1 cycle with evt_ready=1 -> evt_id sequence 0,1,...,7 on consecutive cycles, no drops.
REQ-034 SHALL test backpressure: evt_ready=0, spike_in=8'h01 for 3 consecutive cycles -> one event held, overflow=1, drop_cnt=1 (the third spike, since the second fills pending); releasing ready yields events 0 and 0, then evt_valid=0.
REQ-035 SHALL test simultaneous grant and re-spike: neuron 3 pending and being granted while spike_in[3]=1 -> a second event with evt_id=3 follows, drop_cnt unchanged.
REQ-036 SHALL test saturation and clear: force 300 drops -> drop_cnt=255; clr_stats for 1 cycle with a concurrent drop -> drop_cnt=0, overflow=0.
REQ-037 SHALL test reset mid-operation: rst for 1 cycle while evt_valid=1 and pending=8'hF0 -> evt_valid=0 next cycle, and no events follow without new spikes.
